icosoc_irq_ctrl: RTL and testbench
==================================

// Module: icosoc_irq_ctrl
// PURPOSE
//   Interrupt aggregator downstream of the per-peripheral ctrl_irq outputs (e.g. external-pin irq modules).
//   - Latches one-cycle irq pulses into sticky PENDING bits.
//   - Applies a MASK, reports the highest-priority active source and flags lost (overflowed) pulses.
//   - Drives a single registered cpu_irq line to the CPU.
//   - Programmed over the standard icosoc ctrl register bus.
// PARAMETERS
//   NUM_IRQ  8  number of irq sources, 1..32; bit i = source i, lower index = higher priority
// PORTS
//   Clock and reset: one clock; reset is asynchronous and active-high.
//   clk        in   1        system clock, all state on rising edge
//   reset      in   1        asynchronous, active-high reset
//   irq_in     in   NUM_IRQ  per-source irq pulses, synchronous to clk; each high cycle is one event
//   ctrl_wr    in   1        register write request, held until ctrl_done
//   ctrl_rd    in   1        register read request, held until ctrl_done
//   ctrl_addr  in   8        register byte address
//   ctrl_wdat  in   32       write data
//   ctrl_rdat  out  32       read data, valid in the ctrl_done cycle
//   ctrl_done  out  1        one-cycle access completion pulse
//   cpu_irq    out  1        registered level: high while any PENDING&MASK bit is set
// BEHAVIOUR
//   Reset values: PENDING=0, MASK=0, OVERFLOW=0, ctrl_rdat=0, ctrl_done=0, cpu_irq=0.
//   Register map (bits >= NUM_IRQ read 0, writes ignored):
//     0x00 PENDING   R/W1C  sticky event bits
//     0x04 MASK      R/W    1 = source enabled to cpu_irq
//     0x08 ACTIVE    RO     PENDING & MASK
//     0x0C STATUS    RO     [31]=any active, [4:0]=lowest active index (0 when none)
//     0x10 OVERFLOW  R/W1C  bit i set when irq_in[i] is high while PENDING[i] is already 1
//     other addr     read returns 0, write has no effect; access still completes normally
//   Event capture, per cycle:
//     irq_in[i] sampled at edge k -> PENDING[i]=1 after edge k.
//     Level input held N cycles = N events; repeats set OVERFLOW[i].
//   Masking:
//     Masked sources still latch PENDING and OVERFLOW.
//     Unmasking a pending source raises cpu_irq one cycle later.
//   cpu_irq:
//     Registered from (PENDING & MASK) != 0 as of the previous edge.
//     irq pulse at edge k -> cpu_irq high after edge k+1 (2-cycle latency).
//   Bus handshake:
//     If ctrl_done==0 and (ctrl_wr|ctrl_rd) is high at edge k, then after edge k:
//       ctrl_done=1 for exactly one cycle; write takes effect; ctrl_rdat = register value before edge k.
//     ctrl_done is forced 0 in the cycle after a done, so a held request is never double-completed.
//     ctrl_rdat returns 0 whenever ctrl_done is 0.
//     wr and rd together: both execute; read sees the pre-write value.
//   Simultaneous events:
//     W1C of PENDING[i] in the same cycle as irq_in[i]=1: set wins, PENDING[i] stays 1.
//       OVERFLOW[i] is not set by this case.
//     W1C of OVERFLOW[i] coinciding with a new overflow: set wins.
//   STATUS: priority encoder over ACTIVE; ties resolved to the lowest index.
//   Reset mid-access: state clears immediately; the pending bus request is dropped, no ctrl_done.
//     The master re-issues the request after reset.
// TESTING
//   1 Reset: assert reset with irq_in=all 1s -> all regs 0, cpu_irq=0, ctrl_done=0 while reset is high.
//   2 MASK=0x04, pulse irq_in[2] one cycle at edge k
//       -> PENDING=0x04 after k; cpu_irq=1 after k+1; STATUS=0x80000002.
//       Write 0x04 to 0x00 -> cpu_irq=0 two cycles later.
//   3 MASK=0xFF, pulse irq_in[5] and irq_in[1] together -> STATUS=0x80000001.
//       Clear bit 1 -> STATUS=0x80000005.
//   4 Hold irq_in[3] high 3 cycles, MASK=0 -> PENDING=0x08, OVERFLOW=0x08, cpu_irq stays 0.
//       Then MASK=0x08 -> cpu_irq=1.
//   5 W1C 0x01 to PENDING in the same cycle irq_in[0]=1 -> PENDING[0] remains 1, OVERFLOW[0]=0.
//   6 Hold ctrl_rd high 6 cycles at 0x04 -> ctrl_done pulses on alternating cycles.
//       Read of 0x20 returns 0 with done.
//       Assert reset while ctrl_wr pending -> no ctrl_done, MASK=0.

Source files
------------

// File: rtl/icosoc_irq_ctrl.sv
// Interrupt aggregator for icosoc peripherals.
// Latches one-cycle irq pulses into sticky PENDING bits, masks them, reports
// the lowest-index active source, records lost pulses in OVERFLOW and drives
// a registered cpu_irq level. Programmed over the icosoc ctrl register bus.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   irq_in     per-source irq pulses; each high cycle is one event
//   ctrl_wr    register write request, held until ctrl_done
//   ctrl_rd    register read request, held until ctrl_done
//   ctrl_addr  register byte address
//   ctrl_wdat  write data
//   ctrl_rdat  read data, valid in the ctrl_done cycle, 0 otherwise
//   ctrl_done  one-cycle access completion pulse
//   cpu_irq    high while any PENDING & MASK bit was set at the previous edge
module icosoc_irq_ctrl #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ctrl_wr,
    input  logic               ctrl_rd,
    input  logic [7:0]         ctrl_addr,
    input  logic [31:0]        ctrl_wdat,
    output logic [31:0]        ctrl_rdat,
    output logic               ctrl_done,
    output logic               cpu_irq
);

    localparam logic [7:0] ADDR_PENDING  = 8'h00;
    localparam logic [7:0] ADDR_MASK     = 8'h04;
    localparam logic [7:0] ADDR_ACTIVE   = 8'h08;
    localparam logic [7:0] ADDR_STATUS   = 8'h0C;
    localparam logic [7:0] ADDR_OVERFLOW = 8'h10;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] overflow;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] wdat_irq;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] ovf_clr;
    logic [NUM_IRQ-1:0] ovf_set;
    logic               access;
    logic               wr_en;
    logic [4:0]         low_idx;
    logic [31:0]        status;
    logic [31:0]        rd_mux;
    logic               unused_wdat;

    // A request held across its own done cycle must not complete twice.
    assign access   = (ctrl_wr | ctrl_rd) & ~ctrl_done;
    assign wr_en    = access & ctrl_wr;
    assign wdat_irq = ctrl_wdat[NUM_IRQ-1:0];
    // Upper write-data bits have no backing storage when NUM_IRQ < 32.
    assign unused_wdat = ^ctrl_wdat;

    assign active = pending & mask;

    assign pend_clr = (wr_en && ctrl_addr == ADDR_PENDING)  ? wdat_irq : '0;
    assign ovf_clr  = (wr_en && ctrl_addr == ADDR_OVERFLOW) ? wdat_irq : '0;
    // An event coinciding with its own W1C replaces the cleared one, so it is
    // not counted as lost.
    assign ovf_set  = irq_in & pending & ~pend_clr;

    // Priority encoder: scan downwards so the lowest active index wins.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                low_idx = 5'(i);
            end
        end
    end

    assign status = {|active, 26'd0, low_idx};

    // Read mux over the pre-edge register values.
    always_comb begin
        rd_mux = '0;
        case (ctrl_addr)
            ADDR_PENDING:  rd_mux = 32'(pending);
            ADDR_MASK:     rd_mux = 32'(mask);
            ADDR_ACTIVE:   rd_mux = 32'(active);
            ADDR_STATUS:   rd_mux = status;
            ADDR_OVERFLOW: rd_mux = 32'(overflow);
            default:       rd_mux = '0;
        endcase
    end

    // Register state, bus handshake and cpu_irq.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            mask      <= '0;
            overflow  <= '0;
            ctrl_rdat <= '0;
            ctrl_done <= 1'b0;
            cpu_irq   <= 1'b0;
        end else begin
            pending  <= (pending & ~pend_clr) | irq_in;
            overflow <= (overflow & ~ovf_clr) | ovf_set;
            if (wr_en && ctrl_addr == ADDR_MASK) begin
                mask <= wdat_irq;
            end
            cpu_irq   <= |active;
            ctrl_done <= access;
            ctrl_rdat <= (access && ctrl_rd) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_icosoc_irq_ctrl.sv
// Self-checking bench for icosoc_irq_ctrl: a register-access vector table
// plus hand-written sequences for capture, masking, W1C races and handshake.
module tb_icosoc_irq_ctrl;

    localparam int unsigned NUM_IRQ = 8;

    logic               clk;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_in;
    logic               ctrl_wr;
    logic               ctrl_rd;
    logic [7:0]         ctrl_addr;
    logic [31:0]        ctrl_wdat;
    logic [31:0]        ctrl_rdat;
    logic               ctrl_done;
    logic               cpu_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdat;
        logic [31:0] exp_rdat;
    } vec_t;

    vec_t vecs[14];

    icosoc_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .ctrl_wr   (ctrl_wr),
        .ctrl_rd   (ctrl_rd),
        .ctrl_addr (ctrl_addr),
        .ctrl_wdat (ctrl_wdat),
        .ctrl_rdat (ctrl_rdat),
        .ctrl_done (ctrl_done),
        .cpu_irq   (cpu_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus access; called and returns at a negedge. Expected read data is
    // queued on issue and popped when ctrl_done is seen. irq is driven for the
    // single edge on which the access is taken.
    task automatic bus(input logic wr, input logic rd, input logic [7:0] addr,
                       input logic [31:0] wdat, input logic [31:0] exp,
                       input logic [NUM_IRQ-1:0] irq);
        int n;
        logic [31:0] e;
        ctrl_wr   = wr;
        ctrl_rd   = rd;
        ctrl_addr = addr;
        ctrl_wdat = wdat;
        exp_q.push_back(exp);
        // A done still high from the previous access blocks this edge.
        if (ctrl_done) @(negedge clk);
        irq_in = irq;
        n = 0;
        do begin
            @(negedge clk);
            irq_in = '0;
            n++;
        end while (!ctrl_done && n < 20);
        e = exp_q.pop_front();
        if (!ctrl_done) begin
            checks++;
            failures++;
            $display("FAIL bus_timeout: addr %h got no ctrl_done expected done", addr);
        end else begin
            check($sformatf("rdat@%h", addr), ctrl_rdat, e);
        end
        ctrl_wr = 1'b0;
        ctrl_rd = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp);
        bus(1'b0, 1'b1, addr, 32'd0, exp, '0);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] wdat);
        bus(1'b1, 1'b0, addr, wdat, 32'd0, '0);
    endtask

    task automatic pulse(input logic [NUM_IRQ-1:0] m);
        irq_in = m;
        @(negedge clk);
        irq_in = '0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 8'h04, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b1, 8'h0C, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 8'h10, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 1'b0, 8'h04, 32'hFFFFFFA5, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 8'h04, 32'h0,        32'hA5};
        vecs[6]  = '{1'b1, 1'b1, 8'h04, 32'h3C,       32'hA5};
        vecs[7]  = '{1'b0, 1'b1, 8'h04, 32'h0,        32'h3C};
        vecs[8]  = '{1'b0, 1'b1, 8'h08, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 1'b0, 8'h20, 32'hFF,       32'h0};
        vecs[10] = '{1'b0, 1'b1, 8'h20, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b0, 8'h08, 32'hFF,       32'h0};
        vecs[12] = '{1'b0, 1'b1, 8'h04, 32'h0,        32'h3C};
        vecs[13] = '{1'b1, 1'b0, 8'h04, 32'h0,        32'h0};

        // Reset with every irq high and a read request held.
        reset     = 1'b1;
        irq_in    = '1;
        ctrl_wr   = 1'b0;
        ctrl_rd   = 1'b1;
        ctrl_addr = 8'h00;
        ctrl_wdat = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_done", 32'(ctrl_done), 32'd0);
            check("reset_cpu_irq", 32'(cpu_irq), 32'd0);
            check("reset_rdat", ctrl_rdat, 32'd0);
        end
        irq_in  = '0;
        ctrl_rd = 1'b0;
        reset   = 1'b0;
        @(negedge clk);

        // Register access table.
        for (int i = 0; i < 14; i++) begin
            bus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdat, vecs[i].exp_rdat, '0);
        end

        // Single masked source: pending, 2-cycle cpu_irq latency, clear.
        wr(8'h04, 32'h04);
        pulse(8'h04);
        check("t2_cpu_irq_k", 32'(cpu_irq), 32'd0);
        @(negedge clk);
        check("t2_cpu_irq_k1", 32'(cpu_irq), 32'd1);
        rd(8'h00, 32'h04);
        rd(8'h0C, 32'h80000002);
        rd(8'h08, 32'h04);
        wr(8'h00, 32'h04);
        check("t2_cpu_irq_clr_k", 32'(cpu_irq), 32'd1);
        @(negedge clk);
        check("t2_cpu_irq_clr_k1", 32'(cpu_irq), 32'd0);

        // Priority between two simultaneous sources.
        wr(8'h04, 32'hFF);
        pulse(8'h22);
        rd(8'h0C, 32'h80000001);
        wr(8'h00, 32'h02);
        rd(8'h0C, 32'h80000005);
        wr(8'h00, 32'h20);
        rd(8'h00, 32'h0);
        rd(8'h0C, 32'h0);
        rd(8'h10, 32'h0);

        // Level held 3 cycles while masked: one pending, overflow set.
        wr(8'h04, 32'h00);
        irq_in = 8'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_cpu_irq_masked", 32'(cpu_irq), 32'd0);
        end
        irq_in = '0;
        @(negedge clk);
        check("t4_cpu_irq_masked", 32'(cpu_irq), 32'd0);
        rd(8'h00, 32'h08);
        rd(8'h10, 32'h08);
        rd(8'h08, 32'h00);
        wr(8'h04, 32'h08);
        check("t4_unmask_k", 32'(cpu_irq), 32'd0);
        @(negedge clk);
        check("t4_unmask_k1", 32'(cpu_irq), 32'd1);
        wr(8'h00, 32'h08);
        wr(8'h10, 32'h08);
        wr(8'h04, 32'h00);
        rd(8'h10, 32'h0);
        rd(8'h00, 32'h0);

        // W1C racing a new event: set wins, no overflow.
        pulse(8'h01);
        bus(1'b1, 1'b0, 8'h00, 32'h01, 32'h0, 8'h01);
        rd(8'h00, 32'h01);
        rd(8'h10, 32'h00);
        // Overflow W1C racing a new overflow: set wins.
        pulse(8'h01);
        rd(8'h10, 32'h01);
        bus(1'b1, 1'b0, 8'h10, 32'h01, 32'h0, 8'h01);
        rd(8'h10, 32'h01);
        wr(8'h10, 32'h01);
        rd(8'h10, 32'h00);
        wr(8'h00, 32'h01);
        rd(8'h00, 32'h00);

        // Held read request completes on alternating cycles.
        wr(8'h04, 32'h5A);
        @(negedge clk);
        ctrl_rd   = 1'b1;
        ctrl_addr = 8'h04;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t6_done_%0d", i), 32'(ctrl_done), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t6_rdat_%0d", i), ctrl_rdat, (i % 2 == 0) ? 32'h5A : 32'h0);
        end
        ctrl_rd = 1'b0;
        @(negedge clk);
        rd(8'h20, 32'h0);

        // Reset while a write is pending: dropped, no done, MASK cleared.
        @(negedge clk);
        ctrl_wr   = 1'b1;
        ctrl_addr = 8'h04;
        ctrl_wdat = 32'hFF;
        reset     = 1'b1;
        @(negedge clk);
        check("t6_rst_done", 32'(ctrl_done), 32'd0);
        @(negedge clk);
        check("t6_rst_done2", 32'(ctrl_done), 32'd0);
        ctrl_wr = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        rd(8'h04, 32'h0);
        check("t6_rst_cpu_irq", 32'(cpu_irq), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
